// File: rtl/am2_error_compensator.sv
// ---------------------------------------------------------------------------
// am2_error_compensator
//
// Consumer end of the AM2 error-term path. It adds the aligned compensation
// term from the error-term generator to the truncated approximate product and
// saturates the sum to the product width. A two-stage valid/ready pipeline
// sits between the multiplier core and the result bus.
//
// Optional feature macro: AM2_ERR_STATS_EN
//   When defined, result/saturation statistics counters and the stat_* ports
//   are present. When undefined, they are absent; datapath and timing are
//   identical in both builds.
//
// Ports
//   clk         in   1      rising-edge clock
//   rst_n       in   1      asynchronous active-low reset
//   in_valid    in   1      approx product + error term valid
//   in_ready    out  1      block can accept this cycle
//   in_prod     in   PW     approximate product
//   in_err      in   EW     compensation term, unsigned
//   in_comp_en  in   1      1: apply term, 0: pass product through unchanged
//   out_valid   out  1      corrected result valid
//   out_ready   in   1      downstream accepts
//   out_prod    out  PW     corrected product
//   out_sat     out  1      saturation occurred on this result
//   stat_clr    in   1      [AM2_ERR_STATS_EN] synchronous clear of counters
//   stat_count  out  CNT_W  [AM2_ERR_STATS_EN] results delivered
//   stat_nsat   out  CNT_W  [AM2_ERR_STATS_EN] saturated results delivered
// ---------------------------------------------------------------------------
module am2_error_compensator #(
  parameter int PW        = 16,
  parameter int EW        = 13,
  parameter int ERR_SHIFT = 2
`ifdef AM2_ERR_STATS_EN
  , parameter int CNT_W   = 16
`endif
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_prod,
  input  logic [EW-1:0] in_err,
  input  logic          in_comp_en,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_prod,
  output logic          out_sat
`ifdef AM2_ERR_STATS_EN
  ,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] stat_count,
  output logic [CNT_W-1:0] stat_nsat
`endif
);

  // Internal sum width: wide enough for product plus the shifted term
  // without any possibility of overflow.
  localparam int SW = PW + EW + 1;

  // Add the aligned term and clamp to all-ones on overflow.
  // Returns {sat, product}.
  function automatic logic [PW:0] sat_add(input logic [PW-1:0] prod,
                                          input logic [SW-1:0] term);
    logic [SW-1:0] sum;
    sum = {{(SW-PW){1'b0}}, prod} + term;
    if (|sum[SW-1:PW]) sat_add = {1'b1, {PW{1'b1}}};
    else               sat_add = {1'b0, sum[PW-1:0]};
  endfunction

  logic          vld_p1;
  logic          vld_p2;
  logic [PW-1:0] prod_p1;
  logic [SW-1:0] term_p1;
  logic          s1_adv;
  logic          s2_adv;

  // Stall chain: a stage may load when it is empty or its successor moves.
  assign s2_adv    = ~vld_p2 | out_ready;
  assign s1_adv    = ~vld_p1 | s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = vld_p2;

  // ---- Stage 1: capture operands, align and gate the error term ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
    end else if (s1_adv) begin
      vld_p1 <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid && s1_adv) begin
      prod_p1 <= in_prod;
      term_p1 <= in_comp_en ? (SW'(in_err) << ERR_SHIFT) : '0;
    end
  end

  // ---- Stage 2: saturating add into the output register ----
  // The result register is cleared by reset so the bus idles at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2   <= 1'b0;
      out_prod <= '0;
      out_sat  <= 1'b0;
    end else if (s2_adv) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        {out_sat, out_prod} <= sat_add(prod_p1, term_p1);
      end
    end
  end

`ifdef AM2_ERR_STATS_EN
  // ---- Statistics on delivered results; clear wins over increment ----
  logic out_fire;
  assign out_fire = vld_p2 & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_count <= '0;
      stat_nsat  <= '0;
    end else if (stat_clr) begin
      stat_count <= '0;
      stat_nsat  <= '0;
    end else if (out_fire) begin
      stat_count <= stat_count + 1'b1;
      if (out_sat) stat_nsat <= stat_nsat + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_am2_error_compensator.sv
module tb_am2_error_compensator;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_prod;
  logic [12:0] in_err;
  logic        in_comp_en;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_prod;
  logic        out_sat;
`ifdef AM2_ERR_STATS_EN
  logic        stat_clr;
  logic [15:0] stat_count;
  logic [15:0] stat_nsat;
`endif

  am2_error_compensator #(.PW(16), .EW(13), .ERR_SHIFT(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_prod(in_prod), .in_err(in_err), .in_comp_en(in_comp_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_prod(out_prod), .out_sat(out_sat)
`ifdef AM2_ERR_STATS_EN
    , .stat_clr(stat_clr), .stat_count(stat_count), .stat_nsat(stat_nsat)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference: plain integer arithmetic on the documented rule.
  function automatic logic [16:0] ref_result(input logic [15:0] p, input logic [12:0] e,
                                             input logic en);
    int s;
    s = int'(p) + (en ? int'(e) * 4 : 0);
    if (s > 65535) return {1'b1, 16'hFFFF};
    return {1'b0, 16'(s)};
  endfunction

  typedef struct {
    logic [15:0] prod;
    logic [12:0] err;
    logic        en;
    logic [15:0] exp_prod;
    logic        exp_sat;
  } vec_t;

  vec_t vecs[8];

  // Scoreboard used during the randomized phase.
  logic [16:0] q[$];
  bit          mon_en = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      chk("in_ready_occupancy", {31'd0, in_ready}, {31'd0, !(q.size() == 2 && !out_ready)});
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_output", 32'd1, 32'd0);
        end else begin
          logic [16:0] e;
          e = q.pop_front();
          chk("rand_result", {15'd0, out_sat, out_prod}, {15'd0, e});
        end
      end
      if (in_valid && in_ready) q.push_back(ref_result(in_prod, in_err, in_comp_en));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_vec(input vec_t v, input string nm);
    @(negedge clk);
    in_valid = 1; in_prod = v.prod; in_err = v.err; in_comp_en = v.en; out_ready = 1;
    @(negedge clk);
    in_valid = 0;
    chk({nm, "_lat_not_early"}, {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk({nm, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({nm, "_prod"}, {16'd0, out_prod}, {16'd0, v.exp_prod});
    chk({nm, "_sat"}, {31'd0, out_sat}, {31'd0, v.exp_sat});
  endtask

  initial begin
    vecs[0] = '{16'h1234, 13'h0010, 1'b1, 16'h1274, 1'b0};
    vecs[1] = '{16'hABCD, 13'h1FFF, 1'b0, 16'hABCD, 1'b0};
    vecs[2] = '{16'hFFF0, 13'h0008, 1'b1, 16'hFFFF, 1'b1};
    vecs[3] = '{16'hFFFF, 13'h0000, 1'b1, 16'hFFFF, 1'b0};
    vecs[4] = '{16'h0000, 13'h1FFF, 1'b1, 16'h7FFC, 1'b0};
    vecs[5] = '{16'hFF00, 13'h003F, 1'b1, 16'hFFFC, 1'b0};
    vecs[6] = '{16'hFF00, 13'h0040, 1'b1, 16'hFFFF, 1'b1};
    vecs[7] = '{16'hFFFF, 13'h0001, 1'b0, 16'hFFFF, 1'b0};

    rst_n = 0; in_valid = 0; in_prod = 0; in_err = 0; in_comp_en = 0; out_ready = 0;
`ifdef AM2_ERR_STATS_EN
    stat_clr = 0;
`endif

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_prod", {16'd0, out_prod}, 32'd0);
    chk("rst_out_sat", {31'd0, out_sat}, 32'd0);
    rst_n = 1;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef AM2_ERR_STATS_EN
    chk("rst_stat_count", {16'd0, stat_count}, 32'd0);
    chk("rst_stat_nsat", {16'd0, stat_nsat}, 32'd0);
`endif

    // Table-driven vectors
    for (int i = 0; i < 8; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: three back-to-back inputs while output is stalled
    @(negedge clk);
    out_ready = 0; in_valid = 1; in_comp_en = 1;
    in_prod = 16'h0100; in_err = 13'h0000;
    chk("bp_ready0", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_prod = 16'h0200; in_err = 13'h0001;
    chk("bp_ready1", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_prod = 16'hFFFF; in_err = 13'h0001;
    chk("bp_ready_full", {31'd0, in_ready}, 32'd0);
    chk("bp_hold_a0", {15'd0, out_valid, out_prod}, {15'd0, 1'b1, 16'h0100});
    @(negedge clk);
    chk("bp_ready_full2", {31'd0, in_ready}, 32'd0);
    chk("bp_hold_a1", {15'd0, out_valid, out_prod}, {15'd0, 1'b1, 16'h0100});
    @(negedge clk);
    chk("bp_hold_a2", {16'd0, out_prod}, 32'h0100);
    out_ready = 1;
    #1;
    chk("bp_ready_comb", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 0;
    chk("bp_res_b", {14'd0, out_valid, out_sat, out_prod}, {14'd0, 1'b1, 1'b0, 16'h0204});
    @(negedge clk);
    chk("bp_res_c", {14'd0, out_valid, out_sat, out_prod}, {14'd0, 1'b1, 1'b1, 16'hFFFF});
    @(negedge clk);
    chk("bp_drained", {31'd0, out_valid}, 32'd0);

    // Randomized traffic against the scoreboard
    @(posedge clk);
    mon_en = 1;
    for (int c = 0; c < 2000; c++) begin
      #1;
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 2) != 0);
      in_prod    = ($urandom_range(0, 3) == 0) ? (16'hFF00 | 16'($urandom_range(0, 255)))
                                              : 16'($urandom);
      in_err     = 13'($urandom);
      in_comp_en = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 9) == 0) in_err = 13'd0;
      @(posedge clk);
    end
    #1;
    in_valid = 0; out_ready = 1;
    repeat (6) @(negedge clk);
    chk("rand_drain_empty", q.size(), 32'd0);
    mon_en = 0;
    q.delete();

    // Reset with two results in flight
    @(negedge clk);
    out_ready = 0; in_valid = 1; in_prod = 16'h1111; in_err = 13'h0001; in_comp_en = 1;
    @(negedge clk);
    in_prod = 16'h2222;
    @(negedge clk);
    in_valid = 0;
    chk("mid_full", {31'd0, in_ready}, 32'd0);
    #2;
    rst_n = 0;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_prod", {16'd0, out_prod}, 32'd0);
    @(negedge clk);
    rst_n = 1;
    out_ready = 1;
    @(negedge clk);
    chk("mid_rel_ready", {31'd0, in_ready}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("mid_no_stale%0d", k), {31'd0, out_valid}, 32'd0);
      @(negedge clk);
    end

`ifdef AM2_ERR_STATS_EN
    // Statistics: 5 results, 2 of them saturating
    stat_clr = 1;
    @(negedge clk);
    stat_clr = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; in_comp_en = 1; in_err = 13'h0001;
      in_prod = (i == 1 || i == 3) ? 16'hFFFF : 16'h1000;
      @(negedge clk);
    end
    in_valid = 0;
    repeat (3) @(negedge clk);
    chk("stat_count5", {16'd0, stat_count}, 32'd5);
    chk("stat_nsat2", {16'd0, stat_nsat}, 32'd2);
    // Sixth result held at the output, then consumed in the same cycle as a clear
    out_ready = 0; in_valid = 1; in_prod = 16'hFFFF; in_err = 13'h0004;
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    chk("stat_held_valid", {31'd0, out_valid}, 32'd1);
    stat_clr = 1; out_ready = 1;
    @(negedge clk);
    stat_clr = 0;
    chk("stat_clr_count", {16'd0, stat_count}, 32'd0);
    chk("stat_clr_nsat", {16'd0, stat_nsat}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
